// File: rtl/alu_16.sv
`default_nettype none
// ============================================================================
//  Module   : alu_16
//  Purpose  : 16-bit registered ALU for the execute stage. Performs
//             arithmetic, logic, shift and rotate operations on A and B
//             (with optional carry-in) and registers the result together
//             with an x86-style flag vector one clock after sampling.
//  Ports    : clk    - system clock, rising-edge active
//             rst    - synchronous reset, active-high
//             A, B   - 16-bit operands
//             F      - 5-bit opcode
//             Cin    - carry/borrow input (ADC, SBB, RCL, RCR only)
//             Result - registered 16-bit result
//             Status - registered flags {CF, ZF, NF, VF, PF, AF}
//  Revision : 1.0  initial release
// ============================================================================
module alu_16 (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] A,
    input  logic [15:0] B,
    input  logic [4:0]  F,
    input  logic        Cin,
    output logic [15:0] Result,
    output logic [5:0]  Status
);

    localparam logic [4:0] c_OP_MOV = 5'b00000;
    localparam logic [4:0] c_OP_INC = 5'b00001;
    localparam logic [4:0] c_OP_DEC = 5'b00011;
    localparam logic [4:0] c_OP_ADD = 5'b00100;
    localparam logic [4:0] c_OP_ADC = 5'b00101;
    localparam logic [4:0] c_OP_SUB = 5'b00110;
    localparam logic [4:0] c_OP_SBB = 5'b00111;
    localparam logic [4:0] c_OP_AND = 5'b01000;
    localparam logic [4:0] c_OP_OR  = 5'b01001;
    localparam logic [4:0] c_OP_XOR = 5'b01010;
    localparam logic [4:0] c_OP_NOT = 5'b01011;
    localparam logic [4:0] c_OP_SHL = 5'b10000;
    localparam logic [4:0] c_OP_SHR = 5'b10001;
    localparam logic [4:0] c_OP_SAL = 5'b10010;
    localparam logic [4:0] c_OP_SAR = 5'b10011;
    localparam logic [4:0] c_OP_ROL = 5'b10100;
    localparam logic [4:0] c_OP_ROR = 5'b10101;
    localparam logic [4:0] c_OP_RCL = 5'b10110;
    localparam logic [4:0] c_OP_RCR = 5'b10111;

    localparam logic [5:0] c_STATUS_RST = 6'b010010;

    logic [15:0] result_q;
    logic [5:0]  status_q;
    logic [15:0] result_d;
    logic [5:0]  status_d;

    logic [15:0] w_y;       // effective second operand
    logic        w_carry;   // carry/borrow actually used by the adder
    logic [16:0] w_sum;
    logic [16:0] w_diff;
    logic        w_cf;
    logic        w_vf;
    logic        w_af;

    // Only the two-operand arithmetic forms use B; INC/DEC use a constant 1.
    always_comb begin
        w_y = 16'h0001;
        if (F == c_OP_ADD || F == c_OP_ADC || F == c_OP_SUB || F == c_OP_SBB) begin
            w_y = B;
        end
    end

    assign w_carry = (F == c_OP_ADC || F == c_OP_SBB) ? Cin : 1'b0;

    // Bit 16 of the sum is the carry out; bit 16 of the difference is the
    // borrow, because a wrap below zero sets it in the 17-bit result.
    assign w_sum  = {1'b0, A} + {1'b0, w_y} + {16'd0, w_carry};
    assign w_diff = {1'b0, A} - {1'b0, w_y} - {16'd0, w_carry};

    always_comb begin
        result_d = 16'h0000;
        w_cf     = 1'b0;
        w_vf     = 1'b0;
        w_af     = 1'b0;
        case (F)
            c_OP_MOV: result_d = A;
            c_OP_INC, c_OP_ADD, c_OP_ADC: begin
                result_d = w_sum[15:0];
                w_cf     = w_sum[16];
                w_vf     = (A[15] == w_y[15]) && (w_sum[15] != A[15]);
                w_af     = A[4] ^ w_y[4] ^ w_sum[4];
            end
            c_OP_DEC, c_OP_SUB, c_OP_SBB: begin
                result_d = w_diff[15:0];
                w_cf     = w_diff[16];
                w_vf     = (A[15] != w_y[15]) && (w_diff[15] != A[15]);
                w_af     = A[4] ^ w_y[4] ^ w_diff[4];
            end
            c_OP_AND: result_d = A & B;
            c_OP_OR:  result_d = A | B;
            c_OP_XOR: result_d = A ^ B;
            c_OP_NOT: result_d = ~A;
            c_OP_SHL, c_OP_SAL: begin
                result_d = {A[14:0], 1'b0};
                w_cf     = A[15];
            end
            c_OP_SHR: begin
                result_d = {1'b0, A[15:1]};
                w_cf     = A[0];
            end
            c_OP_SAR: begin
                result_d = {A[15], A[15:1]};
                w_cf     = A[0];
            end
            c_OP_ROL: begin
                result_d = {A[14:0], A[15]};
                w_cf     = A[15];
            end
            c_OP_ROR: begin
                result_d = {A[0], A[15:1]};
                w_cf     = A[0];
            end
            c_OP_RCL: begin
                result_d = {A[14:0], Cin};
                w_cf     = A[15];
            end
            c_OP_RCR: begin
                result_d = {Cin, A[15:1]};
                w_cf     = A[0];
            end
            default: result_d = 16'h0000;
        endcase

        // Shifts and rotates report a sign change between input and output.
        if (F[4:3] == 2'b10) begin
            w_vf = A[15] ^ result_d[15];
        end

        status_d = {w_cf,
                    (result_d == 16'h0000),
                    result_d[15],
                    w_vf,
                    ~^result_d[7:0],
                    w_af};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            result_q <= 16'h0000;
            status_q <= c_STATUS_RST;
        end else begin
            result_q <= result_d;
            status_q <= status_d;
        end
    end

    assign Result = result_q;
    assign Status = status_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_16.sv
`default_nettype none
// ============================================================================
//  Module   : tb_alu_16
//  Purpose  : Self-checking bench for alu_16. Directed vector table with
//             hand-computed results, reset sequences, and a per-opcode
//             random sweep against an independent reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_alu_16;

    logic        clk;
    logic        rst;
    logic [15:0] A;
    logic [15:0] B;
    logic [4:0]  F;
    logic        Cin;
    logic [15:0] Result;
    logic [5:0]  Status;

    int n_checks;
    int n_errors;

    typedef struct {
        string       name;
        logic [4:0]  f;
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
        logic [15:0] res;
        logic [5:0]  st;
    } vec_t;

    vec_t vecs[$];

    alu_16 dut (
        .clk    (clk),
        .rst    (rst),
        .A      (A),
        .B      (B),
        .F      (F),
        .Cin    (Cin),
        .Result (Result),
        .Status (Status)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check16(input string name, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: Result got=%h expected=%h", name, got, exp);
        end
    endtask

    task automatic check6(input string name, input logic [5:0] got, input logic [5:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: Status got=%b expected=%b", name, got, exp);
        end
    endtask

    // Drive inputs, let one rising edge register them, then sample.
    task automatic step(input logic r, input logic [4:0] f, input logic [15:0] a,
                        input logic [15:0] b, input logic c);
        rst = r;
        F   = f;
        A   = a;
        B   = b;
        Cin = c;
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(input string name, input logic [4:0] f, input logic [15:0] a,
                                input logic [15:0] b, input logic cin,
                                input logic [15:0] res, input logic [5:0] st);
        vec_t v;
        v.name = name; v.f = f; v.a = a; v.b = b; v.cin = cin; v.res = res; v.st = st;
        return v;
    endfunction

    // Reference model written with integer arithmetic and signed-range tests,
    // independent of the bit-level formulation inside the design.
    function automatic void model(input logic [4:0] f, input logic [15:0] a, input logic [15:0] b,
                                  input logic cin, output logic [15:0] r, output logic [5:0] s);
        int          ua, uy, uc, t, sa, sy, sr;
        logic [15:0] y;
        logic        cf, vf, af, pf;
        r  = 16'h0000;
        cf = 1'b0;
        vf = 1'b0;
        af = 1'b0;
        y  = (f == 5'b00100 || f == 5'b00101 || f == 5'b00110 || f == 5'b00111) ? b : 16'h0001;
        uc = (f == 5'b00101 || f == 5'b00111) ? int'(cin) : 0;
        ua = int'({16'd0, a});
        uy = int'({16'd0, y});
        sa = $signed(a);
        sy = $signed(y);
        case (f)
            5'b00000: r = a;
            5'b00001, 5'b00100, 5'b00101: begin
                t  = ua + uy + uc;
                r  = t[15:0];
                cf = (t > 65535);
                sr = sa + sy + uc;
                vf = (sr > 32767) || (sr < -32768);
                af = ((ua % 16) + (uy % 16) + uc) > 15;
            end
            5'b00011, 5'b00110, 5'b00111: begin
                t  = ua - uy - uc;
                r  = t[15:0];
                cf = (ua < uy + uc);
                sr = sa - sy - uc;
                vf = (sr > 32767) || (sr < -32768);
                af = (ua % 16) < ((uy % 16) + uc);
            end
            5'b01000: r = a & b;
            5'b01001: r = a | b;
            5'b01010: r = a ^ b;
            5'b01011: r = ~a;
            5'b10000, 5'b10010: begin r = a << 1;                    cf = a[15]; end
            5'b10001: begin r = a >> 1;                              cf = a[0];  end
            5'b10011: begin r = 16'($signed(a) >>> 1);               cf = a[0];  end
            5'b10100: begin r = (a << 1) | (a >> 15);                cf = a[15]; end
            5'b10101: begin r = (a >> 1) | (a << 15);                cf = a[0];  end
            5'b10110: begin r = (a << 1) | {15'd0, cin};             cf = a[15]; end
            5'b10111: begin r = (a >> 1) | {cin, 15'd0};             cf = a[0];  end
            default:  r = 16'h0000;
        endcase
        if (f[4:3] == 2'b10) vf = (a[15] != r[15]);
        pf = ($countones(r[7:0]) % 2) == 0;
        s  = {cf, (r == 16'h0000), r[15], vf, pf, af};
    endfunction

    initial begin
        logic [15:0] er;
        logic [5:0]  es;
        logic [15:0] ra, rb;
        logic        rc;

        n_checks = 0;
        n_errors = 0;
        rst = 1'b1; F = 5'b00100; A = 16'hFFFF; B = 16'hFFFF; Cin = 1'b1;

        // Reset with an active opcode on the inputs must still clear outputs.
        step(1'b1, 5'b00100, 16'hFFFF, 16'hFFFF, 1'b1);
        check16("reset", Result, 16'h0000);
        check6 ("reset", Status, 6'b010010);
        step(1'b0, 5'b00000, 16'h0000, 16'h1234, 1'b1);
        check16("mov0_after_reset", Result, 16'h0000);
        check6 ("mov0_after_reset", Status, 6'b010010);

        vecs.push_back(mk("add_ffff_ffff", 5'b00100, 16'hFFFF, 16'hFFFF, 1'b0, 16'hFFFE, 6'b101001));
        vecs.push_back(mk("inc_ffff",      5'b00001, 16'hFFFF, 16'h0000, 1'b0, 16'h0000, 6'b110011));
        vecs.push_back(mk("sbb_0_0_c1",    5'b00111, 16'h0000, 16'h0000, 1'b1, 16'hFFFF, 6'b101011));
        vecs.push_back(mk("sub_ffff_ffff", 5'b00110, 16'hFFFF, 16'hFFFF, 1'b0, 16'h0000, 6'b010010));
        vecs.push_back(mk("rcr_0001_c1",   5'b10111, 16'h0001, 16'h0000, 1'b1, 16'h8000, 6'b101110));
        vecs.push_back(mk("rcl_ffff_c0",   5'b10110, 16'hFFFF, 16'h0000, 1'b0, 16'hFFFE, 6'b101000));
        vecs.push_back(mk("sar_8001",      5'b10011, 16'h8001, 16'h0000, 1'b0, 16'hC000, 6'b101010));
        vecs.push_back(mk("shr_ffff",      5'b10001, 16'hFFFF, 16'h0000, 1'b0, 16'h7FFF, 6'b100110));
        vecs.push_back(mk("not_0000",      5'b01011, 16'h0000, 16'h0000, 1'b1, 16'hFFFF, 6'b001010));
        vecs.push_back(mk("add_ovf",       5'b00100, 16'h7FFF, 16'h0001, 1'b1, 16'h8000, 6'b001111));
        vecs.push_back(mk("adc_1_2_c1",    5'b00101, 16'h0001, 16'h0002, 1'b1, 16'h0004, 6'b000000));
        vecs.push_back(mk("dec_0000",      5'b00011, 16'h0000, 16'h0000, 1'b0, 16'hFFFF, 6'b101011));
        vecs.push_back(mk("dec_8000",      5'b00011, 16'h8000, 16'hFFFF, 1'b1, 16'h7FFF, 6'b000111));
        vecs.push_back(mk("sub_af",        5'b00110, 16'h0010, 16'h0001, 1'b1, 16'h000F, 6'b000011));
        vecs.push_back(mk("and",           5'b01000, 16'hF0F0, 16'h0FF0, 1'b0, 16'h00F0, 6'b000010));
        vecs.push_back(mk("or_zero",       5'b01001, 16'h0000, 16'h0000, 1'b1, 16'h0000, 6'b010010));
        vecs.push_back(mk("xor",           5'b01010, 16'hAAAA, 16'h5555, 1'b0, 16'hFFFF, 6'b001010));
        vecs.push_back(mk("mov_8003",      5'b00000, 16'h8003, 16'hFFFF, 1'b1, 16'h8003, 6'b001010));
        vecs.push_back(mk("rol_8001",      5'b10100, 16'h8001, 16'h0000, 1'b1, 16'h0003, 6'b100110));
        vecs.push_back(mk("ror_0002",      5'b10101, 16'h0002, 16'h0000, 1'b1, 16'h0001, 6'b000000));
        vecs.push_back(mk("shl_4000",      5'b10000, 16'h4000, 16'h0000, 1'b1, 16'h8000, 6'b001110));
        vecs.push_back(mk("sal_8000",      5'b10010, 16'h8000, 16'h0000, 1'b0, 16'h0000, 6'b110110));
        vecs.push_back(mk("inc_cin_ign",   5'b00001, 16'h0000, 16'hFFFF, 1'b1, 16'h0001, 6'b000000));
        vecs.push_back(mk("rsv_00010",     5'b00010, 16'hFFFF, 16'hFFFF, 1'b1, 16'h0000, 6'b010010));
        vecs.push_back(mk("rsv_11111",     5'b11111, 16'h8001, 16'h7FFF, 1'b1, 16'h0000, 6'b010010));

        foreach (vecs[i]) begin
            step(1'b0, vecs[i].f, vecs[i].a, vecs[i].b, vecs[i].cin);
            check16(vecs[i].name, Result, vecs[i].res);
            check6 (vecs[i].name, Status, vecs[i].st);
        end

        // Reset asserted in the middle of a stream overrides the pending op,
        // and the very next op resumes normally.
        step(1'b0, 5'b00100, 16'hFFFF, 16'hFFFF, 1'b0);
        step(1'b1, 5'b01011, 16'h0000, 16'h0000, 1'b0);
        check16("midstream_reset", Result, 16'h0000);
        check6 ("midstream_reset", Status, 6'b010010);
        step(1'b0, 5'b01011, 16'h0000, 16'h0000, 1'b0);
        check16("after_midstream_reset", Result, 16'hFFFF);
        check6 ("after_midstream_reset", Status, 6'b001010);

        // Random sweep across all 32 codes, back-to-back every cycle.
        for (int op = 0; op < 32; op++) begin
            for (int k = 0; k < 5; k++) begin
                ra = 16'($urandom);
                rb = 16'($urandom);
                rc = 1'($urandom);
                model(5'(op), ra, rb, rc, er, es);
                step(1'b0, 5'(op), ra, rb, rc);
                check16($sformatf("rand op=%b A=%h B=%h Cin=%b", 5'(op), ra, rb, rc), Result, er);
                check6 ($sformatf("rand op=%b A=%h B=%h Cin=%b", 5'(op), ra, rb, rc), Status, es);
            end
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
